// File: rtl/imem_sync.sv
// Synchronous instruction memory for the fetch stage: registered read with
// stall hold, runtime program-load port, post-reset NOP clear and fault flag.
module imem_sync #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DEPTH          = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD       = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_stall,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_fault,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic                  prog_ack
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IDX = $clog2(DEPTH);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [IDX:0]          LAST_PTR   = (IDX + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFF) - 1);

  // Misaligned low bits or any bit above the word index makes an address bad;
  // the index is never allowed to wrap.
  function automatic logic f_badAddr(input logic [ADDR_WIDTH-1:0] a);
    return (|(a & ALIGN_MASK)) || (|(a >> (IDX + OFF)));
  endfunction

  logic [0:0]            r_state;
  logic [IDX:0]          r_clearPtr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_run;
  logic                  w_fetchBad;
  logic                  w_progOk;
  logic                  w_collide;
  logic [IDX-1:0]        w_fetchIdx;
  logic [IDX-1:0]        w_progIdx;
  logic [DATA_WIDTH-1:0] w_readWord;

  assign w_run       = (r_state == S_RUN);
  assign fetch_ready = w_run;
  assign w_fetchIdx  = fetch_addr[IDX+OFF-1:OFF];
  assign w_progIdx   = prog_addr[IDX+OFF-1:OFF];
  assign w_fetchBad  = f_badAddr(fetch_addr);
  assign w_progOk    = w_run && prog_we && !f_badAddr(prog_addr);
  assign w_collide   = w_progOk && (w_progIdx == w_fetchIdx);
  assign w_readWord  = w_collide ? prog_data : r_mem[w_fetchIdx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      r_clearPtr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clearPtr <= r_clearPtr + 1'b1;
      if (r_clearPtr == LAST_PTR) r_state <= S_RUN;
    end
  end

  // Array has no reset; the clear sequence owns initialisation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) r_mem[r_clearPtr[IDX-1:0]] <= NOP_WORD;
      else if (w_progOk)      r_mem[w_progIdx]           <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_data  <= NOP_WORD;
      prog_ack    <= 1'b0;
    end else begin
      prog_ack <= w_progOk;
      if (w_run && !fetch_stall) begin
        if (fetch_req) begin
          fetch_valid <= 1'b1;
          fetch_fault <= w_fetchBad;
          fetch_data  <= w_fetchBad ? NOP_WORD : w_readWord;
        end else begin
          fetch_valid <= 1'b0;
          fetch_fault <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Directed testbench for imem_sync: one instance with the clear sequence and
// one without, both DEPTH=16 with 32-bit words.
module tb_imem_sync;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        fetchReq, fetchStall, progWe;
  logic [31:0] fetchAddr, progAddr, progData;
  logic        fetchReady, fetchValid, fetchFault, progAck;
  logic [31:0] fetchData;

  logic        d2Req, d2Stall, d2We;
  logic [31:0] d2Addr, d2PAddr, d2PData;
  logic        d2Ready, d2Valid, d2Fault, d2Ack;
  logic [31:0] d2Data;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  imem_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16),
              .NOP_WORD(32'h0), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetchReq), .fetch_addr(fetchAddr), .fetch_stall(fetchStall),
    .fetch_ready(fetchReady), .fetch_valid(fetchValid), .fetch_data(fetchData),
    .fetch_fault(fetchFault),
    .prog_we(progWe), .prog_addr(progAddr), .prog_data(progData), .prog_ack(progAck)
  );

  imem_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16),
              .NOP_WORD(32'h0), .CLEAR_ON_RESET(1'b0)) dut2 (
    .clk(clk), .rst(rst2),
    .fetch_req(d2Req), .fetch_addr(d2Addr), .fetch_stall(d2Stall),
    .fetch_ready(d2Ready), .fetch_valid(d2Valid), .fetch_data(d2Data),
    .fetch_fault(d2Fault),
    .prog_we(d2We), .prog_addr(d2PAddr), .prog_data(d2PData), .prog_ack(d2Ack)
  );

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    fetchReq = 0; fetchStall = 0; progWe = 0;
    fetchAddr = 0; progAddr = 0; progData = 0;
    d2Req = 0; d2Stall = 0; d2We = 0; d2Addr = 0; d2PAddr = 0; d2PData = 0;
    tick(); tick();
    checks++; if (fetchReady !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", fetchReady); end
    checks++; if (fetchValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", fetchValid); end
    checks++; if (fetchFault !== 1'b0) begin fails++; $display("[TB] FAIL reset_fault: got %b expected 0", fetchFault); end
    checks++; if (fetchData !== 32'h0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00000000", fetchData); end
    checks++; if (progAck !== 1'b0) begin fails++; $display("[TB] FAIL reset_ack: got %b expected 0", progAck); end
    checks++; if (d2Ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready_noclear: got %b expected 1", d2Ready); end
  endtask

  task automatic test_clear();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      fetchReq = 1'b1; fetchAddr = 32'h0; progWe = 1'b1; progAddr = 32'h0; progData = 32'hFFFF_FFFF;
      tick();
      checks++;
      if (fetchReady !== (k == 16)) begin
        fails++; $display("[TB] FAIL clear_ready_k%0d: got %b expected %b", k, fetchReady, (k == 16));
      end
      if (k < 16) begin
        checks++; if (fetchValid !== 1'b0) begin fails++; $display("[TB] FAIL clear_ignores_fetch_k%0d: got %b expected 0", k, fetchValid); end
      end
    end
    progWe = 1'b0;
    for (int a = 0; a < 16; a++) begin
      fetchReq = 1'b1; fetchAddr = 32'(a * 4);
      tick();
      checks++;
      if (fetchValid !== 1'b1 || fetchData !== 32'h0 || fetchFault !== 1'b0) begin
        fails++; $display("[TB] FAIL clear_word_%0d: got v=%b d=%h f=%b expected v=1 d=00000000 f=0", a, fetchValid, fetchData, fetchFault);
      end
    end
    fetchReq = 1'b0;
    tick();
  endtask

  task automatic test_load();
    progWe = 1'b1; progAddr = 32'h0; progData = 32'h3c180007;
    tick();
    checks++; if (progAck !== 1'b1) begin fails++; $display("[TB] FAIL load_ack0: got %b expected 1", progAck); end
    progAddr = 32'h8; progData = 32'h24100140;
    tick();
    checks++; if (progAck !== 1'b1) begin fails++; $display("[TB] FAIL load_ack8: got %b expected 1", progAck); end
    progWe = 1'b0;
    tick();
    checks++; if (progAck !== 1'b0) begin fails++; $display("[TB] FAIL load_ack_drop: got %b expected 0", progAck); end
    fetchReq = 1'b1; fetchAddr = 32'h8;
    tick();
    checks++;
    if (fetchValid !== 1'b1 || fetchData !== 32'h24100140 || fetchFault !== 1'b0) begin
      fails++; $display("[TB] FAIL load_fetch8: got v=%b d=%h f=%b expected v=1 d=24100140 f=0", fetchValid, fetchData, fetchFault);
    end
    fetchReq = 1'b0;
    tick();
    checks++;
    if (fetchValid !== 1'b0 || fetchData !== 32'h24100140) begin
      fails++; $display("[TB] FAIL idle_hold: got v=%b d=%h expected v=0 d=24100140", fetchValid, fetchData);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    addrs = '{32'h0, 32'h4, 32'h8};
    exps  = '{32'h3c180007, 32'h0, 32'h24100140};
    for (int i = 0; i < 3; i++) begin
      fetchReq = 1'b1; fetchAddr = addrs[i];
      tick();
      checks++;
      if (fetchValid !== 1'b1 || fetchData !== exps[i]) begin
        fails++; $display("[TB] FAIL b2b_%0d: got v=%b d=%h expected v=1 d=%h", i, fetchValid, fetchData, exps[i]);
      end
    end
    fetchReq = 1'b0;
    tick();
  endtask

  task automatic test_fault();
    fetchReq = 1'b1; fetchAddr = 32'h0;
    tick();
    fetchAddr = 32'h6;
    tick();
    checks++;
    if (fetchValid !== 1'b1 || fetchFault !== 1'b1 || fetchData !== 32'h0) begin
      fails++; $display("[TB] FAIL fault_misaligned: got v=%b f=%b d=%h expected v=1 f=1 d=00000000", fetchValid, fetchFault, fetchData);
    end
    fetchAddr = 32'h40;
    tick();
    checks++; if (fetchFault !== 1'b1) begin fails++; $display("[TB] FAIL fault_range: got %b expected 1", fetchFault); end
    fetchAddr = 32'h3C;
    tick();
    checks++; if (fetchFault !== 1'b0) begin fails++; $display("[TB] FAIL top_index_ok: got %b expected 0", fetchFault); end
    fetchReq = 1'b0;
    tick();
    checks++; if (fetchFault !== 1'b0) begin fails++; $display("[TB] FAIL fault_clear_idle: got %b expected 0", fetchFault); end
    progWe = 1'b1; progAddr = 32'h41; progData = 32'hDEADBEEF;
    tick();
    checks++; if (progAck !== 1'b0) begin fails++; $display("[TB] FAIL badwrite_ack41: got %b expected 0", progAck); end
    progAddr = 32'h40;
    tick();
    checks++; if (progAck !== 1'b0) begin fails++; $display("[TB] FAIL badwrite_ack40: got %b expected 0", progAck); end
    progWe = 1'b0; fetchReq = 1'b1; fetchAddr = 32'h0;
    tick();
    checks++;
    if (fetchData !== 32'h3c180007) begin
      fails++; $display("[TB] FAIL badwrite_unchanged: got %h expected 3c180007", fetchData);
    end
    fetchReq = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    fetchReq = 1'b1; fetchAddr = 32'h0;
    tick();
    fetchStall = 1'b1; fetchAddr = 32'h8;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (fetchValid !== 1'b1 || fetchData !== 32'h3c180007) begin
        fails++; $display("[TB] FAIL stall_hold_%0d: got v=%b d=%h expected v=1 d=3c180007", c, fetchValid, fetchData);
      end
    end
    fetchStall = 1'b0;
    tick();
    tick();
    checks++;
    if (fetchValid !== 1'b1 || fetchData !== 32'h24100140) begin
      fails++; $display("[TB] FAIL stall_release: got v=%b d=%h expected v=1 d=24100140", fetchValid, fetchData);
    end
    fetchStall = 1'b1; fetchReq = 1'b0;
    progWe = 1'b1; progAddr = 32'hC; progData = 32'h11112222;
    tick();
    checks++;
    if (fetchValid !== 1'b1 || fetchData !== 32'h24100140 || progAck !== 1'b1) begin
      fails++; $display("[TB] FAIL stall_write: got v=%b d=%h ack=%b expected v=1 d=24100140 ack=1", fetchValid, fetchData, progAck);
    end
    progWe = 1'b0; fetchStall = 1'b0; fetchReq = 1'b1; fetchAddr = 32'hC;
    tick();
    checks++; if (fetchData !== 32'h11112222) begin fails++; $display("[TB] FAIL stall_write_commit: got %h expected 11112222", fetchData); end
    fetchReq = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    progWe = 1'b1; progAddr = 32'h4; progData = 32'h26730001;
    fetchReq = 1'b1; fetchAddr = 32'h4;
    tick();
    checks++;
    if (fetchData !== 32'h26730001 || progAck !== 1'b1) begin
      fails++; $display("[TB] FAIL collision: got d=%h ack=%b expected d=26730001 ack=1", fetchData, progAck);
    end
    progWe = 1'b0; fetchReq = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    fetchReq = 1'b1; fetchAddr = 32'h0;
    tick();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (fetchReady !== 1'b0 || fetchValid !== 1'b0 || fetchData !== 32'h0) begin
      fails++; $display("[TB] FAIL async_reset: got r=%b v=%b d=%h expected r=0 v=0 d=00000000", fetchReady, fetchValid, fetchData);
    end
    fetchReq = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (fetchReady !== (k == 16)) begin
        fails++; $display("[TB] FAIL restart_ready_k%0d: got %b expected %b", k, fetchReady, (k == 16));
      end
    end
    fetchReq = 1'b1; fetchAddr = 32'h0;
    tick();
    checks++; if (fetchData !== 32'h0) begin fails++; $display("[TB] FAIL recleared: got %h expected 00000000", fetchData); end
    fetchReq = 1'b0;
  endtask

  task automatic test_no_clear();
    rst2 = 1'b0;
    d2Req = 1'b1; d2Addr = 32'h4;
    d2We = 1'b1; d2PAddr = 32'h8; d2PData = 32'h24100140;
    tick();
    checks++; if (d2Valid !== 1'b1) begin fails++; $display("[TB] FAIL noclear_first_fetch: got %b expected 1", d2Valid); end
    checks++; if (d2Ack !== 1'b1) begin fails++; $display("[TB] FAIL noclear_ack: got %b expected 1", d2Ack); end
    d2We = 1'b0; d2Req = 1'b0;
    #1 rst2 = 1'b1;
    #1;
    checks++;
    if (d2Ack !== 1'b0 || d2Valid !== 1'b0 || d2Ready !== 1'b1) begin
      fails++; $display("[TB] FAIL noclear_async: got ack=%b v=%b r=%b expected ack=0 v=0 r=1", d2Ack, d2Valid, d2Ready);
    end
    tick();
    rst2 = 1'b0;
    d2Req = 1'b1; d2Addr = 32'h8;
    tick();
    checks++; if (d2Data !== 32'h24100140) begin fails++; $display("[TB] FAIL noclear_preserved: got %h expected 24100140", d2Data); end
    d2Req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_load();
    test_back_to_back();
    test_fault();
    test_stall();
    test_collision();
    test_reset_mid_clear();
    test_no_clear();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
# imem_sync

Parametrised synchronous instruction memory for the pipeline CPU fetch stage.
- Registered one-cycle read with request/valid handshake and IF-stall hold.
- Runtime program-load port, so images are written by a loader instead of being hard-coded.
- Post-reset clear sequence that fills every word with a NOP.
- Fault flag for misaligned or out-of-range fetch addresses.

## Interface
- DATA_WIDTH, 32, instruction word width in bits; must be a power of two ≥ 8.
- ADDR_WIDTH, 32, byte-address width of fetch and program ports.
- DEPTH, 256, number of words; must be a power of two.
- NOP_WORD, 32'h00000000, value returned on a fault and written during clear.
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- fetch_req  in  1  fetch request from the IF stage.
- fetch_addr  in  ADDR_WIDTH  byte address of the instruction.
- fetch_stall  in  1  IF stall; holds all fetch outputs.
- fetch_ready  out  1  high in RUN state.
- fetch_valid  out  1  fetch_data/fetch_fault hold the result of an accepted request.
- fetch_data  out  DATA_WIDTH  instruction word.
- fetch_fault  out  1  accepted request was misaligned or out of range.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  ADDR_WIDTH  byte address for the write.
- prog_data  in  DATA_WIDTH  word to write.
- prog_ack  out  1  one-cycle pulse: previous-cycle write was committed.

## Operation
Derived quantities:
- OFF = log2(DATA_WIDTH/8).
- IDX = log2(DEPTH).
- Word index = fetch_addr[IDX+OFF-1:OFF].
- Address is misaligned if fetch_addr[OFF-1:0] ≠ 0.
- Address is out of range if any bit of fetch_addr at or above IDX+OFF is set.
- The same rules apply to prog_addr.

State machine, two states:
- CLEAR:
  - clear_ptr (IDX+1 bits) writes NOP_WORD to mem[clear_ptr], one word per cycle.
  - After mem[DEPTH-1] is written, the next state is RUN.
  - CLEAR lasts exactly DEPTH cycles.
  - fetch_req and prog_we are ignored.
- RUN:
  - Normal operation; no exit except rst.
- Reset state is CLEAR with clear_ptr=0 if CLEAR_ON_RESET=1, otherwise RUN.

Fetch (RUN only):
- A request is accepted when fetch_req=1 and fetch_stall=0.
- On the edge that accepts a request:
  - fetch_valid ← 1.
  - fetch_fault ← misaligned OR out of range.
  - fetch_data ← NOP_WORD if faulting, else mem[index].
- When fetch_stall=1: fetch_valid, fetch_data and fetch_fault hold, regardless of fetch_req.
- When fetch_req=0 and fetch_stall=0: fetch_valid ← 0, fetch_fault ← 0, fetch_data holds.

Program port (RUN only):
- A write is committed when prog_we=1 and prog_addr is aligned and in range: mem[index] ← prog_data.
- prog_ack ← 1 on the next edge; otherwise prog_ack ← 0.
- Bad-address writes are dropped with no ack.
- A write in the same cycle as an accepted fetch to the same index is write-first: fetch_data returns prog_data.

Reset:
- Output reset values:
  - fetch_valid=0, fetch_fault=0, fetch_data=NOP_WORD, prog_ack=0.
  - fetch_ready=0 if CLEAR_ON_RESET=1, otherwise 1.
- The memory array is not reset asynchronously; the clear sequence handles it.

## Timing
- Fetch latency: 1 cycle, from the accepting edge to fetch_valid/fetch_data.
- Throughput: one fetch per cycle while unstalled.
- fetch_ready is decoded from the state register, with no combinational path from inputs.
- fetch_ready rises on the edge that writes mem[DEPTH-1], i.e. DEPTH edges after rst falls.
- A request in the first RUN cycle is accepted.
- rst asserted mid-CLEAR: clear_ptr returns to 0 and the full DEPTH-cycle clear restarts.
- rst asserted mid-RUN:
  - All outputs go to reset values immediately, not on a clock edge.
  - Any pending prog_ack is lost.
  - Contents are re-cleared if CLEAR_ON_RESET=1 and preserved if 0.
- Write plus stalled fetch in the same cycle: the write commits and fetch outputs hold their old values.
- Highest index DEPTH-1 is valid. Index DEPTH (range overflow) is a fault; the index must not wrap.

## Test plan
- Clear: DEPTH=16, CLEAR_ON_RESET=1, release rst.
  - fetch_ready=0 for 16 cycles, then 1.
  - Fetch addresses 0x00..0x3C: every word = 0x00000000, fetch_fault=0.
- Load and fetch:
  - prog writes 0x3c180007@0x0, 0x24100140@0x8; prog_ack pulses once per write.
  - Fetch 0x8 → next cycle fetch_valid=1, fetch_data=0x24100140.
- Faults:
  - Fetch 0x6 → fetch_fault=1, data=NOP_WORD.
  - Fetch 0x40 with DEPTH=16 → fetch_fault=1.
  - prog_we to 0x41 → no prog_ack, memory unchanged.
- Stall:
  - Fetch 0x0 then assert fetch_stall for 3 cycles while fetch_addr=0x8.
  - fetch_data stays 0x3c180007 and fetch_valid=1 throughout.
  - Two cycles after stall drops, fetch_data=0x24100140.
- Write-first collision:
  - Same cycle: prog_we@0x4 data 0x26730001 and fetch 0x4.
  - fetch_data=0x26730001 next cycle.
- Reset mid-clear:
  - Assert rst at clear cycle 7.
  - fetch_ready stays 0 for 16 full cycles after release.
  - With CLEAR_ON_RESET=0, loaded contents survive a mid-RUN reset.
